// File: rtl/change_dispensing.sv
// change_dispensing
//   Back end of the 20-cent vending path. A purchase request from the coin
//   acceptor (exceed_i with deposit_i >= PRICE) releases a soda for one cycle.
//   The change (deposit - PRICE) is then paid to the coin hopper in dimes and
//   nickels, one coin per valid/ready handshake. The block tracks hopper stock.
//   It also buffers one request that arrives while a payout is in progress.
// Ports
//   clk_i, rst_i      clock, synchronous active-high reset
//   exceed_i          purchase request strobe, deposit_i = cents deposited
//   refill_i          reload both stock counters (honoured in IDLE only)
//   coin_ready_i      hopper accepts the presented coin this cycle
//   soda_o            one-cycle soda release pulse
//   coin_valid_o      a change coin is presented, coin_dime_o 1=dime 0=nickel
//   busy_o            state != IDLE
//   short_o           one-cycle pulse: change could not be completed from stock
//   owed_o            cents still unpaid after a short, held until next request
//   lost_o            one-cycle pulse: a request was dropped (pending slot full)
//   nickle_cnt_o      nickel stock
//   dime_cnt_o        dime stock
module change_dispensing #(
    parameter int PRICE       = 20,
    parameter int STOCK_W     = 4,
    parameter int NICKLE_INIT = 8,
    parameter int DIME_INIT   = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               exceed_i,
    input  logic [5:0]         deposit_i,
    input  logic               refill_i,
    input  logic               coin_ready_i,
    output logic               soda_o,
    output logic               coin_valid_o,
    output logic               coin_dime_o,
    output logic               busy_o,
    output logic               short_o,
    output logic [5:0]         owed_o,
    output logic               lost_o,
    output logic [STOCK_W-1:0] nickle_cnt_o,
    output logic [STOCK_W-1:0] dime_cnt_o
);

    localparam logic [5:0]         L_PRICE     = 6'(PRICE);
    localparam logic [STOCK_W-1:0] L_NICK_INIT = STOCK_W'(NICKLE_INIT);
    localparam logic [STOCK_W-1:0] L_DIME_INIT = STOCK_W'(DIME_INIT);
    localparam logic [STOCK_W-1:0] L_ONE       = STOCK_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VEND   = 2'd1,
        S_CHANGE = 2'd2,
        S_SHORT  = 2'd3
    } state_t;

    state_t             r_state;
    logic [5:0]         r_rem;
    logic [5:0]         r_owed;
    logic               r_pend_v;
    logic [5:0]         r_pend_dep;
    logic               r_lost;
    logic [STOCK_W-1:0] r_nick;
    logic [STOCK_W-1:0] r_dime;

    state_t             w_state_nxt;
    logic [5:0]         w_rem_nxt;
    logic [5:0]         w_owed_nxt;
    logic               w_pend_v_nxt;
    logic [5:0]         w_pend_dep_nxt;
    logic               w_lost_nxt;
    logic [STOCK_W-1:0] w_nick_nxt;
    logic [STOCK_W-1:0] w_dime_nxt;
    logic               w_req;
    logic               w_dime_ok;
    logic               w_nick_ok;
    logic               w_coin_valid;
    logic [5:0]         w_rem_paid;

    // The guard on the deposit keeps deposit - PRICE from underflowing.
    assign w_req = exceed_i && (deposit_i >= L_PRICE);

    // The coin choice depends only on registered state. That keeps coin_dime_o
    // stable while the hopper stalls. A nickel also needs at least 5 cents owed,
    // so an odd remainder ends in SHORT instead of wrapping.
    assign w_dime_ok    = (r_rem >= 6'd10) && (r_dime != '0);
    assign w_nick_ok    = (r_rem >= 6'd5) && (r_nick != '0);
    assign w_coin_valid = (r_state == S_CHANGE) && (w_dime_ok || w_nick_ok);
    assign w_rem_paid   = w_dime_ok ? (r_rem - 6'd10) : (r_rem - 6'd5);

    assign soda_o       = (r_state == S_VEND);
    assign coin_valid_o = w_coin_valid;
    assign coin_dime_o  = (r_state == S_CHANGE) && w_dime_ok;
    assign busy_o       = (r_state != S_IDLE);
    assign short_o      = (r_state == S_SHORT);
    assign owed_o       = r_owed;
    assign lost_o       = r_lost;
    assign nickle_cnt_o = r_nick;
    assign dime_cnt_o   = r_dime;

    // State register and datapath registers, with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_rem      <= 6'd0;
            r_owed     <= 6'd0;
            r_pend_v   <= 1'b0;
            r_pend_dep <= 6'd0;
            r_lost     <= 1'b0;
            r_nick     <= L_NICK_INIT;
            r_dime     <= L_DIME_INIT;
        end else begin
            r_state    <= w_state_nxt;
            r_rem      <= w_rem_nxt;
            r_owed     <= w_owed_nxt;
            r_pend_v   <= w_pend_v_nxt;
            r_pend_dep <= w_pend_dep_nxt;
            r_lost     <= w_lost_nxt;
            r_nick     <= w_nick_nxt;
            r_dime     <= w_dime_nxt;
        end
    end

    // Next-state logic, payout arithmetic and pending-slot management.
    always_comb begin
        w_state_nxt    = r_state;
        w_rem_nxt      = r_rem;
        w_owed_nxt     = r_owed;
        w_pend_v_nxt   = r_pend_v;
        w_pend_dep_nxt = r_pend_dep;
        w_lost_nxt     = 1'b0;
        w_nick_nxt     = r_nick;
        w_dime_nxt     = r_dime;

        // While busy, a live request goes to the slot if the slot is free.
        // Otherwise the request is dropped.
        if ((r_state != S_IDLE) && w_req) begin
            if (!r_pend_v) begin
                w_pend_v_nxt   = 1'b1;
                w_pend_dep_nxt = deposit_i;
            end else begin
                w_lost_nxt = 1'b1;
            end
        end else begin
            w_lost_nxt = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (r_pend_v) begin
                    // The pending request runs first. A simultaneous live
                    // request refills the slot in the same cycle.
                    w_rem_nxt   = r_pend_dep - L_PRICE;
                    w_owed_nxt  = 6'd0;
                    w_state_nxt = S_VEND;
                    if (w_req) begin
                        w_pend_dep_nxt = deposit_i;
                    end else begin
                        w_pend_v_nxt = 1'b0;
                    end
                end else if (w_req) begin
                    w_rem_nxt   = deposit_i - L_PRICE;
                    w_owed_nxt  = 6'd0;
                    w_state_nxt = S_VEND;
                end else if (refill_i) begin
                    w_nick_nxt = L_NICK_INIT;
                    w_dime_nxt = L_DIME_INIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_VEND: begin
                if (r_rem != 6'd0) begin
                    w_state_nxt = S_CHANGE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CHANGE: begin
                if (!w_coin_valid) begin
                    w_state_nxt = S_SHORT;
                end else if (coin_ready_i) begin
                    w_rem_nxt = w_rem_paid;
                    if (w_dime_ok) begin
                        w_dime_nxt = r_dime - L_ONE;
                    end else begin
                        w_nick_nxt = r_nick - L_ONE;
                    end
                    if (w_rem_paid == 6'd0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_CHANGE;
                    end
                end else begin
                    w_state_nxt = S_CHANGE;
                end
            end
            S_SHORT: begin
                w_owed_nxt  = r_rem;
                w_rem_nxt   = 6'd0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_rem_nxt   = 6'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_change_dispensing.sv
module tb_change_dispensing;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       exceed_i;
    logic [5:0] deposit_i;
    logic       refill_i;
    logic       coin_ready_i;
    logic       soda_o;
    logic       coin_valid_o;
    logic       coin_dime_o;
    logic       busy_o;
    logic       short_o;
    logic [5:0] owed_o;
    logic       lost_o;
    logic [3:0] nickle_cnt_o;
    logic [3:0] dime_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    change_dispensing dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .exceed_i     (exceed_i),
        .deposit_i    (deposit_i),
        .refill_i     (refill_i),
        .coin_ready_i (coin_ready_i),
        .soda_o       (soda_o),
        .coin_valid_o (coin_valid_o),
        .coin_dime_o  (coin_dime_o),
        .busy_o       (busy_o),
        .short_o      (short_o),
        .owed_o       (owed_o),
        .lost_o       (lost_o),
        .nickle_cnt_o (nickle_cnt_o),
        .dime_cnt_o   (dime_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       exc;
        logic [5:0] dep;
        logic       refill;
        logic       rdy;
        logic       soda;
        logic       valid;
        logic       dime;
        logic       busy;
        logic [3:0] nick_cnt;
        logic [3:0] dime_cnt;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mk(input logic exc, input logic [5:0] dep, input logic refill,
                                input logic rdy, input logic soda, input logic valid,
                                input logic dime, input logic busy,
                                input logic [3:0] nc, input logic [3:0] dc);
        vec_t v;
        v.exc = exc; v.dep = dep; v.refill = refill; v.rdy = rdy;
        v.soda = soda; v.valid = valid; v.dime = dime; v.busy = busy;
        v.nick_cnt = nc; v.dime_cnt = dc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // A full purchase with the hopper always ready, bounded wait for idle.
    task automatic purchase(input logic [5:0] dep);
        exceed_i = 1'b1; deposit_i = dep; coin_ready_i = 1'b1;
        tick();
        exceed_i = 1'b0;
        for (int k = 0; k < 40 && busy_o; k++) tick();
        check("purchase_done_busy", 32'(busy_o), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; exceed_i = 1'b0; deposit_i = 6'd0; refill_i = 1'b0; coin_ready_i = 1'b0;

        vecs[0]  = mk(1'b1, 6'd25, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd8, 4'd8);
        vecs[1]  = mk(1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd8, 4'd8);
        vecs[2]  = mk(1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 4'd8);
        vecs[3]  = mk(1'b1, 6'd40, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 4'd8);
        vecs[4]  = mk(1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 4'd8);
        vecs[5]  = mk(1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'd7, 4'd7);
        vecs[6]  = mk(1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd7, 4'd6);
        vecs[7]  = mk(1'b0, 6'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 4'd8);
        vecs[8]  = mk(1'b1, 6'd19, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 4'd8);
        vecs[9]  = mk(1'b1, 6'd20, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd8, 4'd8);
        vecs[10] = mk(1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd8, 4'd8);

        tick(); tick();
        rst_i = 1'b0;
        tick();
        check("rst_busy",  32'(busy_o), 32'd0);
        check("rst_soda",  32'(soda_o), 32'd0);
        check("rst_valid", 32'(coin_valid_o), 32'd0);
        check("rst_short", 32'(short_o), 32'd0);
        check("rst_lost",  32'(lost_o), 32'd0);
        check("rst_owed",  32'(owed_o), 32'd0);
        check("rst_nick",  32'(nickle_cnt_o), 32'd8);
        check("rst_dime",  32'(dime_cnt_o), 32'd8);

        // Table: 25 -> one nickel, 40 -> two dimes, refill, 19 ignored, 20 no change.
        for (int i = 0; i < 11; i++) begin
            exceed_i = vecs[i].exc; deposit_i = vecs[i].dep;
            refill_i = vecs[i].refill; coin_ready_i = vecs[i].rdy;
            tick();
            check($sformatf("v%0d_soda", i),  32'(soda_o), 32'(vecs[i].soda));
            check($sformatf("v%0d_valid", i), 32'(coin_valid_o), 32'(vecs[i].valid));
            if (vecs[i].valid) check($sformatf("v%0d_dime", i), 32'(coin_dime_o), 32'(vecs[i].dime));
            check($sformatf("v%0d_busy", i),  32'(busy_o), 32'(vecs[i].busy));
            check($sformatf("v%0d_short", i), 32'(short_o), 32'd0);
            check($sformatf("v%0d_ncnt", i),  32'(nickle_cnt_o), 32'(vecs[i].nick_cnt));
            check($sformatf("v%0d_dcnt", i),  32'(dime_cnt_o), 32'(vecs[i].dime_cnt));
        end
        exceed_i = 1'b0; refill_i = 1'b0;

        // Dimes drained: 40 pays four nickels, hopper stalls on the 2nd coin.
        for (int i = 0; i < 4; i++) purchase(6'd40);
        check("drain_dime", 32'(dime_cnt_o), 32'd0);
        check("drain_nick", 32'(nickle_cnt_o), 32'd8);
        exceed_i = 1'b1; deposit_i = 6'd40; coin_ready_i = 1'b1;
        tick();
        exceed_i = 1'b0;
        tick();
        check("nk_c1_valid", 32'(coin_valid_o), 32'd1);
        check("nk_c1_dime",  32'(coin_dime_o), 32'd0);
        tick();
        check("nk_c2_valid", 32'(coin_valid_o), 32'd1);
        check("nk_c2_nick",  32'(nickle_cnt_o), 32'd7);
        coin_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nk_hold_valid", 32'(coin_valid_o), 32'd1);
            check("nk_hold_dime",  32'(coin_dime_o), 32'd0);
            check("nk_hold_nick",  32'(nickle_cnt_o), 32'd7);
        end
        coin_ready_i = 1'b1;
        tick(); tick(); tick();
        check("nk_end_busy", 32'(busy_o), 32'd0);
        check("nk_end_nick", 32'(nickle_cnt_o), 32'd4);

        // Empty hopper: 25 -> soda then SHORT with 5 owed.
        purchase(6'd40);
        check("empty_nick", 32'(nickle_cnt_o), 32'd0);
        exceed_i = 1'b1; deposit_i = 6'd25;
        tick();
        exceed_i = 1'b0;
        check("sh_soda", 32'(soda_o), 32'd1);
        tick();
        check("sh_valid", 32'(coin_valid_o), 32'd0);
        check("sh_busy",  32'(busy_o), 32'd1);
        tick();
        check("sh_short", 32'(short_o), 32'd1);
        tick();
        check("sh_short_end", 32'(short_o), 32'd0);
        check("sh_owed",      32'(owed_o), 32'd5);
        check("sh_busy_end",  32'(busy_o), 32'd0);
        refill_i = 1'b1;
        tick();
        refill_i = 1'b0;
        check("refill_nick", 32'(nickle_cnt_o), 32'd8);
        check("refill_dime", 32'(dime_cnt_o), 32'd8);

        // Buffered and lost requests during a 40-cent payout.
        exceed_i = 1'b1; deposit_i = 6'd40;
        tick();
        check("bf_owed_clr", 32'(owed_o), 32'd0);
        deposit_i = 6'd25;
        tick();
        check("bf_lost0", 32'(lost_o), 32'd0);
        tick();
        check("bf_lost1", 32'(lost_o), 32'd1);
        exceed_i = 1'b0;
        tick();
        check("bf_lost_end", 32'(lost_o), 32'd0);
        check("bf_idle",     32'(busy_o), 32'd0);
        tick();
        check("bf_pend_soda", 32'(soda_o), 32'd1);
        tick();
        check("bf_pend_valid", 32'(coin_valid_o), 32'd1);
        check("bf_pend_dime",  32'(coin_dime_o), 32'd0);
        tick();
        check("bf_end_busy", 32'(busy_o), 32'd0);
        check("bf_end_nick", 32'(nickle_cnt_o), 32'd7);
        check("bf_end_dime", 32'(dime_cnt_o), 32'd6);
        tick();
        check("bf_no_third", 32'(soda_o), 32'd0);

        // Refill ignored in VEND, then reset mid-CHANGE.
        exceed_i = 1'b1; deposit_i = 6'd25;
        tick();
        exceed_i = 1'b0; refill_i = 1'b1;
        tick();
        refill_i = 1'b0; coin_ready_i = 1'b0;
        check("rv_nick",  32'(nickle_cnt_o), 32'd7);
        check("rv_dime",  32'(dime_cnt_o), 32'd6);
        check("rv_valid", 32'(coin_valid_o), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mr_busy",  32'(busy_o), 32'd0);
        check("mr_valid", 32'(coin_valid_o), 32'd0);
        check("mr_soda",  32'(soda_o), 32'd0);
        check("mr_owed",  32'(owed_o), 32'd0);
        check("mr_nick",  32'(nickle_cnt_o), 32'd8);
        check("mr_dime",  32'(dime_cnt_o), 32'd8);
        tick();
        check("mr_stay_idle", 32'(busy_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
